// File: rtl/moving_avg_filter_if.sv
`default_nettype none
// ============================================================================
// moving_avg_filter_if
// Sample-stream handshake between the audio source, the filter and the DAC.
// Revision: 1.0
// ============================================================================
interface moving_avg_filter_if #(
   parameter int DATA_W = 16
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_data;
   logic                     out_valid;
   logic signed [DATA_W-1:0] out_data;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      output out_data
   );
endinterface
`default_nettype wire

// File: rtl/moving_avg_filter.sv
`default_nettype none
// ============================================================================
// moving_avg_filter
// Signed streaming moving average (running sum over a circular window) with
// bypass / lowpass / highpass / mute output modes.
// Revision: 1.0
// ============================================================================
module moving_avg_filter #(
   parameter int DATA_W     = 16,
   parameter int LOG2_DEPTH = 5
) (
   input  wire                clk,
   input  wire                rst,
   input  wire                en,
   input  wire                clear,
   input  wire [1:0]          mode,
   output logic               busy,
   moving_avg_filter_if.slave s_if
);
   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int ACC_W = DATA_W + LOG2_DEPTH;
   localparam logic [LOG2_DEPTH-1:0]    PTR_LAST = {LOG2_DEPTH{1'b1}};
   localparam logic signed [DATA_W-1:0] SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] SAT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t                   state_q, state_d;
   logic [LOG2_DEPTH-1:0]    ptr_q, ptr_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [DATA_W-1:0] win_q [DEPTH];
   logic signed [DATA_W-1:0] win_d [DEPTH];
   logic                     out_valid_q, out_valid_d;
   logic signed [DATA_W-1:0] out_data_q, out_data_d;

   logic                     in_ready;
   logic                     accept;
   logic signed [DATA_W-1:0] old_sample;
   logic signed [ACC_W-1:0]  acc_n;
   logic signed [DATA_W-1:0] avg;
   logic signed [DATA_W:0]   hp_diff;
   logic signed [DATA_W-1:0] hp_sat;
   logic signed [DATA_W-1:0] result;

   assign in_ready       = (state_q == ST_RUN) && en && !clear;
   assign accept         = in_ready && s_if.in_valid;
   assign s_if.in_ready  = in_ready;
   assign s_if.out_valid = out_valid_q;
   assign s_if.out_data  = out_data_q;
   assign busy           = (state_q == ST_CLEAR);

   // Dropping the low LOG2_DEPTH bits of the two's-complement sum is the
   // arithmetic shift, so the average floors toward minus infinity.
   always_comb begin
      old_sample = win_q[ptr_q];
      acc_n      = acc_q
                 + {{LOG2_DEPTH{s_if.in_data[DATA_W-1]}}, s_if.in_data}
                 - {{LOG2_DEPTH{old_sample[DATA_W-1]}}, old_sample};
      avg        = acc_n[ACC_W-1:LOG2_DEPTH];
      hp_diff    = {s_if.in_data[DATA_W-1], s_if.in_data} - {avg[DATA_W-1], avg};
      if (hp_diff[DATA_W] != hp_diff[DATA_W-1]) begin
         hp_sat = hp_diff[DATA_W] ? SAT_MIN : SAT_MAX;
      end else begin
         hp_sat = hp_diff[DATA_W-1:0];
      end
      case (mode)
         2'b00:   result = s_if.in_data;
         2'b01:   result = avg;
         2'b10:   result = hp_sat;
         default: result = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      acc_d       = acc_q;
      win_d       = win_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      case (state_q)
         ST_CLEAR: begin
            win_d[ptr_q] = '0;
            acc_d        = '0;
            if (clear) begin
               ptr_d = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
               if (ptr_q == PTR_LAST) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (clear) begin
               state_d = ST_CLEAR;
               ptr_d   = '0;
               acc_d   = '0;
            end else if (accept) begin
               win_d[ptr_q] = s_if.in_data;
               acc_d        = acc_n;
               ptr_d        = ptr_q + 1'b1;
               out_valid_d  = 1'b1;
               out_data_d   = result;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_CLEAR;
         ptr_q       <= '0;
         acc_q       <= '0;
         win_q       <= '{default: '0};
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         acc_q       <= acc_d;
         win_q       <= win_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_moving_avg_filter.sv
`default_nettype none
// ============================================================================
// tb_moving_avg_filter
// Self-checking bench: cycle monitor with a window reference model, constant
// vector table, hand sequences for reset/clear, and gap-equivalence runs.
// Revision: 1.0
// ============================================================================
module tb_moving_avg_filter;
   localparam int DATA_W     = 16;
   localparam int LOG2_DEPTH = 5;
   localparam int DEPTH      = 1 << LOG2_DEPTH;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       clear;
   logic [1:0] mode;
   logic       busy;

   moving_avg_filter_if #(.DATA_W(DATA_W)) ifc ();

   moving_avg_filter #(
      .DATA_W     (DATA_W),
      .LOG2_DEPTH (LOG2_DEPTH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .clear (clear),
      .mode  (mode),
      .busy  (busy),
      .s_if  (ifc)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: plain window of the last DEPTH samples
   int  win[$];
   int  cnt;
   bit  pending;
   int  exp_data;
   bit  exp_rdy;
   bit  rec_en = 1'b0;
   int  rec_q[$];

   function automatic void win_zero();
      win.delete();
      for (int i = 0; i < DEPTH; i++) win.push_back(0);
   endfunction

   function automatic int model_step(input logic [1:0] m, input int d);
      int s, q, r;
      win.push_back(d);
      void'(win.pop_front());
      s = 0;
      foreach (win[i]) s += win[i];
      q = s / DEPTH;
      if ((s % DEPTH) != 0 && s < 0) q = q - 1;
      case (m)
         2'b00:   r = d;
         2'b01:   r = q;
         2'b10: begin
            r = d - q;
            if (r > 32767)  r = 32767;
            if (r < -32768) r = -32768;
         end
         default: r = 0;
      endcase
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_out_valid", ifc.out_valid, 0);
         chk("rst_out_data", $signed(ifc.out_data), 0);
         chk("rst_busy", busy, 1);
         chk("rst_in_ready", ifc.in_ready, 0);
         cnt      = DEPTH;
         pending  = 1'b0;
         exp_data = 0;
         win_zero();
      end else begin
         chk("mon_busy", busy, (cnt != 0));
         exp_rdy = (cnt == 0) && en && !clear;
         chk("mon_in_ready", ifc.in_ready, exp_rdy);
         chk("mon_out_valid", ifc.out_valid, pending);
         chk("mon_out_data", $signed(ifc.out_data), exp_data);
         if (rec_en && ifc.out_valid === 1'b1) rec_q.push_back(int'($signed(ifc.out_data)));
         pending = exp_rdy && (ifc.in_valid === 1'b1);
         if (pending) exp_data = model_step(mode, int'($signed(ifc.in_data)));
         if (cnt != 0) begin
            if (clear) cnt = DEPTH;
            else cnt--;
         end else if (clear) begin
            cnt = DEPTH;
            win_zero();
         end
      end
   end

   // ---------------- constant vector table
   typedef struct {
      bit         do_clear;
      logic [1:0] mode;
      int         din;
      int         exp;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input bit c, input logic [1:0] m, input int d, input int e);
      vec_t v;
      v.do_clear = c;
      v.mode     = m;
      v.din      = d;
      v.exp      = e;
      tbl.push_back(v);
   endfunction

   task automatic clear_window();
      bit ok;
      @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      ok = 1'b0;
      for (int t = 0; t < 4 * DEPTH; t++) begin
         @(negedge clk);
         if (busy === 1'b0) begin ok = 1'b1; break; end
      end
      chk("clear_done_timeout", ok, 1);
   endtask

   task automatic send(input logic [1:0] m, input int d);
      bit ok;
      @(posedge clk); #1;
      en           = 1'b1;
      mode         = m;
      ifc.in_data  = d[15:0];
      ifc.in_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 4 * DEPTH; t++) begin
         @(negedge clk);
         if (ifc.in_ready === 1'b1) begin ok = 1'b1; break; end
      end
      chk("send_timeout", ok, 1);
      @(posedge clk); #1 ifc.in_valid = 1'b0;
   endtask

   logic [15:0] seq_d [64];
   logic [1:0]  seq_m [64];
   int          ref_q[$];
   int          cyc;
   int          busy_cnt;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1);
   end

   initial begin
      rst          = 1'b1;
      en           = 1'b1;
      clear        = 1'b0;
      mode         = 2'b01;
      ifc.in_valid = 1'b1;
      ifc.in_data  = 16'sd1000;

      // reset release with traffic already waiting; step of 1000 in lowpass
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      cyc = 0;
      for (int t = 0; t < 4 * DEPTH; t++) begin
         @(negedge clk);
         if (ifc.in_ready === 1'b1) break;
         cyc++;
      end
      chk("first_accept_cycle", cyc, DEPTH);
      @(negedge clk);
      chk("step_first_valid", ifc.out_valid, 1);
      chk("step_first_out", $signed(ifc.out_data), 31);
      repeat (40) @(negedge clk);
      chk("step_settled", $signed(ifc.out_data), 1000);

      // clear pulse while in_valid stays high
      @(posedge clk); #1 clear = 1'b1;
      @(negedge clk);
      chk("clear_cycle_ready", ifc.in_ready, 0);
      @(posedge clk); #1 clear = 1'b0;
      busy_cnt = 0;
      for (int t = 0; t < 4 * DEPTH; t++) begin
         @(negedge clk);
         if (busy !== 1'b1) break;
         busy_cnt++;
      end
      chk("clear_busy_cycles", busy_cnt, DEPTH);
      @(negedge clk);
      chk("clear_first_valid", ifc.out_valid, 1);
      chk("clear_first_out", $signed(ifc.out_data), 31);

      // asynchronous reset while an output pulse is owed
      @(posedge clk); #2;
      chk("pre_rst_out_valid", ifc.out_valid, 1);
      rst = 1'b1;
      #1;
      chk("async_rst_out_valid", ifc.out_valid, 0);
      chk("async_rst_busy", busy, 1);
      chk("async_rst_out_data", $signed(ifc.out_data), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      ifc.in_valid = 1'b0;

      // table: step, impulse, highpass saturation, mute then lowpass
      for (int k = 1; k <= 40; k++) add(k == 1, 2'b01, 1000, (k <= DEPTH) ? (1000 * k) / DEPTH : 1000);
      add(1'b1, 2'b01, -1, -1);
      for (int k = 2; k <= 40; k++) add(1'b0, 2'b01, 0, (k <= DEPTH) ? -1 : 0);
      for (int k = 0; k < DEPTH; k++) add(1'b0, 2'b00, -32768, -32768);
      add(1'b0, 2'b10, 32767, 32767);
      add(1'b0, 2'b10, 0, 29697);
      add(1'b0, 2'b11, 5, 0);
      add(1'b0, 2'b00, 123, 123);
      for (int k = 0; k < DEPTH; k++) add(k == 0, 2'b11, 1000, 0);
      add(1'b0, 2'b01, 1000, 1000);

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].do_clear) clear_window();
         send(tbl[i].mode, tbl[i].din);
         @(negedge clk);
         chk($sformatf("table_valid[%0d]", i), ifc.out_valid, 1);
         chk($sformatf("table_out[%0d]", i), $signed(ifc.out_data), tbl[i].exp);
      end

      // same random sequence, gap-free and then with en/in_valid gaps
      for (int i = 0; i < 64; i++) begin
         seq_d[i] = 16'($urandom_range(0, 65535));
         seq_m[i] = 2'($urandom_range(0, 3));
      end
      clear_window();
      rec_q.delete();
      rec_en = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(posedge clk); #1;
         en = 1'b1; ifc.in_valid = 1'b1; mode = seq_m[i]; ifc.in_data = seq_d[i];
      end
      @(posedge clk); #1 ifc.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rec_en = 1'b0;
      ref_q = rec_q;

      clear_window();
      rec_q.delete();
      rec_en = 1'b1;
      for (int i = 0; i < 64; i++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
            mode        = 2'($urandom_range(0, 3));
            ifc.in_data = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 1) == 1) begin
               en = 1'b0; ifc.in_valid = 1'b1;
            end else begin
               en = 1'b1; ifc.in_valid = 1'b0;
            end
         end
         @(posedge clk); #1;
         en = 1'b1; ifc.in_valid = 1'b1; mode = seq_m[i]; ifc.in_data = seq_d[i];
      end
      @(posedge clk); #1 ifc.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rec_en = 1'b0;
      chk("gapfree_count", ref_q.size(), 64);
      chk("gapped_count", rec_q.size(), 64);
      for (int i = 0; i < 64 && i < rec_q.size() && i < ref_q.size(); i++)
         chk($sformatf("gap_equiv[%0d]", i), rec_q[i], ref_q[i]);

      // free-running random traffic including stray clears
      for (int t = 0; t < 400; t++) begin
         @(posedge clk); #1;
         en           = ($urandom_range(0, 3) != 0);
         ifc.in_valid = ($urandom_range(0, 1) == 1);
         clear        = ($urandom_range(0, 49) == 0);
         mode         = 2'($urandom_range(0, 3));
         ifc.in_data  = 16'($urandom_range(0, 65535));
      end
      @(posedge clk); #1;
      clear        = 1'b0;
      ifc.in_valid = 1'b0;
      repeat (3) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/moving_avg_filter.md
# moving_avg_filter

Parametrised, signed, streaming moving-average filter for the audio path, replacing the fixed 32-tap unsigned lowpass. It keeps a circular sample buffer and a running sum, so the cost is one add and one subtract per sample rather than a DEPTH-input adder tree. It provides bypass, lowpass, highpass and mute modes behind a valid/ready handshake, and sits between the audio sample source and the output DAC stage.

## Interface
- DATA_W, 16, sample width; two's-complement signed.
- LOG2_DEPTH, 5, log2 of window length; DEPTH = 2^LOG2_DEPTH, legal range 1..8.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  enable; when low, no samples are accepted and all state holds.
- clear  in  1  synchronous request to zero the window (single-cycle pulse or level).
- mode  in  2  output mode: 00 bypass, 01 lowpass, 10 highpass, 11 mute.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  signed input sample.
- out_valid  out  1  one-cycle pulse; out_data valid.
- out_data  out  DATA_W  signed filtered sample.
- busy  out  1  high while in the CLEAR state.

## Operation
- Storage:
  - Buffer of DEPTH x DATA_W registers, write/read pointer ptr of LOG2_DEPTH bits.
  - Signed accumulator acc of DATA_W+LOG2_DEPTH bits; this width cannot overflow.
- FSM states: CLEAR and RUN.
- CLEAR:
  - Each cycle writes 0 to buf[ptr] and increments ptr.
  - acc is held at 0.
  - After DEPTH cycles, moves to RUN with ptr = 0.
  - Runs regardless of en.
- RUN: in_ready = en & ~clear. Accept = in_valid & in_ready.
- On accept:
  - old = buf[ptr]
  - buf[ptr] <= in_data
  - acc_n = acc + in_data - old (sign-extended); acc <= acc_n
  - ptr <= ptr + 1, wrapping from DEPTH-1 to 0
- avg = acc_n >>> LOG2_DEPTH (arithmetic shift, which floors toward -inf).
- Output, computed from the mode sampled at accept:
  - bypass: in_data
  - lowpass: avg
  - highpass: in_data - avg at DATA_W+1 bits, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]
  - mute: 0
- The window is updated in every mode, so a mode switch takes effect immediately with no re-fill.
- clear asserted in RUN: the sample in that cycle is not accepted (in_ready is low); next state is CLEAR with ptr = 0 and acc = 0.
- clear asserted in CLEAR: restarts the DEPTH-cycle count from ptr = 0.
- Window warm-up: the window starts zero-filled, so outputs before DEPTH samples average against zeros. There is no fill-count normalisation.

## Timing
- Reset values:
  - State CLEAR, ptr 0, acc 0.
  - in_ready 0, busy 1, out_valid 0, out_data 0.
- After rst deasserts, busy is high for exactly DEPTH cycles. in_ready can first be high on cycle DEPTH, counting the first cycle after release as cycle 0.
- Latency: out_valid pulses exactly 1 cycle after the accept cycle. out_data is registered and holds its value until the next pulse.
- Throughput: one sample per cycle when in_valid, en and RUN are sustained.
- en low:
  - in_ready is 0.
  - No buffer or accumulator change.
  - An out_valid pulse already owed from the previous cycle's accept is still issued.
- rst mid-stream: all outputs return to their reset values immediately (asynchronously), and any pending out_valid is dropped.
- in_ready is combinational from state, en and clear only. It must not depend on in_valid.

## Test plan
- Reset release with en = 1 and in_valid = 1:
  - busy is high for 32 cycles and in_ready is 0 throughout.
  - First accept on cycle 32.
  - out_valid exactly one cycle after each accept.
- Lowpass step, in = 1000 constant:
  - Output k (k = 1..32) = floor(1000k/32), i.e. 31, 62, 93, …, 1000.
  - Holds 1000 from sample 32 on.
- Lowpass impulse -1 followed by zeros: 32 outputs of -1 (floor behaviour), then 0.
- Highpass saturation: fill the window with -32768, then input 32767.
  - avg = -30721, raw result 63488.
  - Required out_data = 32767.
- Throttling:
  - Randomised in_valid/en gaps give outputs identical to the gap-free run.
  - Bypass echoes the input.
  - Mute gives 0 while the window keeps updating: switching to lowpass afterwards yields the correct average immediately.
- clear pulse mid-stream with in_valid held high:
  - The sample in the clear cycle is not accepted; busy is high for 32 cycles.
  - After clear, step 1000 gives 31 as the first output.
  - rst asserted mid-stream drops the pending out_valid.
